// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with a 2-FF input synchronizer and single mid-bit sampling
module uart_byte_receiver #(
  parameter int CLK_PER_BIT = 868,
  parameter int DATA_BITS   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UART_RX,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLK_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic rx_m, rx_s;
  // bring the asynchronous line into the clock domain; idle-high reset value avoids a false start
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {UART_RX, rx_m};
  // frame FSM: half-bit wait to mid start bit, then one sample per bit period
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      data <= '0;
      valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE:
          if (!rx_s) begin
            state <= START;
            busy <= 1'b1;
            cnt <= '0;
            bit_idx <= '0;
          end
        START:
          if (cnt == HALF_M1) begin
            cnt <= '0;
            state <= rx_s ? IDLE : DATA;
            busy <= !rx_s;
          end else cnt <= cnt + 1'b1;
        DATA:
          if (cnt == FULL_M1) begin
            cnt <= '0;
            shreg[bit_idx] <= rx_s;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= STOP;
          end else cnt <= cnt + 1'b1;
        STOP:
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              data <= shreg;
              valid <= 1'b1;
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state <= WAIT_HIGH;
            end
          end else cnt <= cnt + 1'b1;
        WAIT_HIGH:
          if (rx_s) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed and random frames checked against a line-history sampling model
module tb_uart_byte_receiver;
  localparam int P = 16;
  localparam int H = P / 2;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic UART_RX = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int errors = 0;
  int checks = 0;
  int cyc = -1;
  bit line [0:65535];
  int mode = 0;
  int u = 0;
  logic [7:0] dexp = 8'h00;
  logic vexp = 1'b0, fexp = 1'b0, bexp = 1'b0;
  int nvalid = 0, nferr = 0, vcyc = 0;
  logic [7:0] vq[$];

  uart_byte_receiver #(.CLK_PER_BIT(P), .DATA_BITS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .UART_RX(UART_RX),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // line value as the receiver's synchronizer sees it at each rising edge
  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (cyc <= 65535) line[cyc] = RST_N ? UART_RX : 1'b1;
  end

  // model: a frame begins at the first low line index u; bit k is line[u+H+k*P]
  always @(negedge CLK) if (cyc >= 2 && cyc <= 65535) begin
    int i;
    vexp = 1'b0;
    fexp = 1'b0;
    if (!RST_N) begin
      mode = 0;
      dexp = 8'h00;
    end else begin
      i = cyc - 2;
      if (mode == 0) begin
        if (!line[i]) begin
          u = i;
          mode = 1;
        end
      end else if (mode == 2) begin
        if (line[i]) mode = 0;
      end else if (i == u + H && line[i]) mode = 0;
      else if (i == u + H + 9 * P) begin
        if (line[i]) begin
          vexp = 1'b1;
          for (int k = 0; k < 8; k++) dexp[k] = line[u + H + (k + 1) * P];
          mode = 0;
        end else begin
          fexp = 1'b1;
          mode = 2;
        end
      end
    end
    bexp = (mode != 0);
    chk("valid", 32'(valid), 32'(vexp));
    chk("frame_err", 32'(frame_err), 32'(fexp));
    chk("busy", 32'(busy), 32'(bexp));
    chk("data", 32'(data), 32'(dexp));
    if (valid === 1'b1) begin
      nvalid++;
      vcyc = cyc;
      vq.push_back(data);
    end
    if (frame_err === 1'b1) nferr++;
  end

  task automatic drive(input logic v, input int n);
    UART_RX = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input int bl, input logic stop);
    drive(1'b0, bl);
    for (int k = 0; k < 8; k++) drive(b[k], bl);
    drive(stop, bl);
  endtask

  initial begin
    int t0, n0, f0;
    logic [7:0] b;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    RST_N = 1'b1;
    drive(1'b1, 10);
    t0 = cyc; n0 = nvalid; f0 = nferr;
    send(8'hA5, P, 1'b1);
    drive(1'b1, 20);
    chk("a5_latency", 32'(vcyc - t0), 32'd155);
    chk("a5_count", 32'(nvalid - n0), 32'd1);
    chk("a5_data", 32'(data), 32'hA5);
    chk("a5_busy_after", 32'(busy), 32'h0);
    chk("a5_no_ferr", 32'(nferr - f0), 32'd0);
    n0 = nvalid;
    send(8'hFF, P, 1'b1);
    send(8'h00, P, 1'b1);
    send(8'h3C, P, 1'b1);
    drive(1'b1, 20);
    chk("b2b_count", 32'(nvalid - n0), 32'd3);
    chk("b2b_0", 32'(vq[vq.size() - 3]), 32'hFF);
    chk("b2b_1", 32'(vq[vq.size() - 2]), 32'h00);
    chk("b2b_2", 32'(vq[vq.size() - 1]), 32'h3C);
    n0 = nvalid; f0 = nferr;
    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("glitch_valid", 32'(nvalid - n0), 32'd0);
    chk("glitch_ferr", 32'(nferr - f0), 32'd0);
    chk("glitch_busy", 32'(busy), 32'h0);
    n0 = nvalid; f0 = nferr;
    send(8'h5A, P, 1'b0);
    drive(1'b0, 5 * P);
    drive(1'b1, 2 * P);
    chk("break_ferr", 32'(nferr - f0), 32'd1);
    chk("break_data_kept", 32'(data), 32'h3C);
    chk("break_no_valid", 32'(nvalid - n0), 32'd0);
    send(8'h12, P, 1'b1);
    drive(1'b1, 20);
    chk("after_break", 32'(data), 32'h12);
    b = 8'h81;
    drive(1'b0, P);
    for (int k = 0; k < 4; k++) drive(b[k], P);
    drive(b[4], H);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_data", 32'(data), 32'h00);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    chk("rst_mid_ferr", 32'(frame_err), 32'h0);
    drive(1'b1, 5);
    RST_N = 1'b1;
    drive(1'b1, 12 * P);
    send(8'h7E, P, 1'b1);
    drive(1'b1, 20);
    chk("after_reset", 32'(data), 32'h7E);
    send(8'hC3, P - 1, 1'b1);
    drive(1'b1, 20);
    chk("skew_fast", 32'(data), 32'hC3);
    drive(1'b1, 20);
    chk("skew_idle", 32'(data), 32'hC3);
    send(8'h00, P, 1'b1);
    drive(1'b1, 20);
    send(8'hC3, P + 1, 1'b1);
    drive(1'b1, 20);
    chk("skew_slow", 32'(data), 32'hC3);
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 5) == 0) drive(1'b0, $urandom_range(1, H - 1));
      drive(1'b1, $urandom_range(0, 3));
      send(8'($urandom), P + $urandom_range(0, 2) - 1, $urandom_range(0, 6) != 0);
      drive(1'b1, $urandom_range(0, 20));
    end
    drive(1'b1, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
